mem_arbiter: RTL

- Shares the single off-chip memory port (256-bit line, enable/write/ack handshake) between the instruction-side cache (port 0) and the data cache (port 1).
- Sits between the CPU-level cache tops and the memory model. Each cache keeps its existing memory protocol unchanged.
- Serialises whole-line transactions, arbitrates round-robin or fixed-priority, inserts a release gap between transactions, and flags ack timeouts.

---
 rtl/mem_arbiter_pkg.sv | 15 +
 rtl/mem_arbiter_pick2.sv | 26 ++
 rtl/mem_arbiter.sv | 136 +++++++++++++
 3 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the two-port memory arbiter: FSM encoding,
// requester port indices and the default line width.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    GAP  = 2'd2
  } arb_state_e;

  localparam int PORT_I = 0;
  localparam int PORT_D = 1;
  localparam int LINE_W = 256;

endpackage

// File: rtl/mem_arbiter_pick2.sv
// Combinational two-requester picker: round-robin on the last owner,
// or fixed priority to the data port when mode_i is set.
module arb_pick2
  import mem_arbiter_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       last_i,
  input  logic       mode_i,
  output logic [1:0] win_o
);

  always_comb begin
    win_o = '0;
    if (req_i[PORT_I] && req_i[PORT_D]) begin
      // last_i is the index of the previous owner; the other port wins a tie
      if (mode_i || !last_i) begin
        win_o[PORT_D] = 1'b1;
      end else begin
        win_o[PORT_I] = 1'b1;
      end
    end else begin
      win_o = req_i;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one line-wide memory port between the icache (port 0) and the
// dcache (port 1), one whole transaction at a time with a release gap.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = LINE_W,
  parameter int PRIO_MODE = 0,
  parameter int TIMEOUT   = 64
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              p0_enable_i,
  input  logic              p0_write_i,
  input  logic [ADDR_W-1:0] p0_addr_i,
  input  logic [DATA_W-1:0] p0_data_i,
  output logic [DATA_W-1:0] p0_data_o,
  output logic              p0_ack_o,
  input  logic              p1_enable_i,
  input  logic              p1_write_i,
  input  logic [ADDR_W-1:0] p1_addr_i,
  input  logic [DATA_W-1:0] p1_data_i,
  output logic [DATA_W-1:0] p1_data_o,
  output logic              p1_ack_o,
  input  logic [DATA_W-1:0] mem_data_i,
  input  logic              mem_ack_i,
  output logic [DATA_W-1:0] mem_data_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic              mem_enable_o,
  output logic              mem_write_o,
  output logic [1:0]        grant_o,
  output logic              busy_o,
  output logic              err_o
);

  // Wide enough to reach TIMEOUT and then saturate one above it
  localparam int CNT_W = $clog2(TIMEOUT + 2);

  arb_state_e        state_q, state_d;
  logic [1:0]        grant_q, grant_d;
  logic              last_q, last_d;
  logic              mem_en_q, mem_en_d;
  logic              mem_wr_q, mem_wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              err_q, err_d;
  logic [1:0]        win;

  arb_pick2 u_pick (
    .req_i  ({p1_enable_i, p0_enable_i}),
    .last_i (last_q),
    .mode_i (PRIO_MODE != 0),
    .win_o  (win)
  );

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    last_d   = last_q;
    mem_en_d = mem_en_q;
    mem_wr_d = mem_wr_q;
    addr_d   = addr_q;
    data_d   = data_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    case (state_q)
      IDLE: begin
        if (|win) begin
          grant_d  = win;
          mem_en_d = 1'b1;
          mem_wr_d = win[PORT_D] ? p1_write_i : p0_write_i;
          addr_d   = win[PORT_D] ? p1_addr_i  : p0_addr_i;
          data_d   = win[PORT_D] ? p1_data_i  : p0_data_i;
          cnt_d    = '0;
          state_d  = BUSY;
        end
      end
      BUSY: begin
        if (cnt_q != '1) begin
          cnt_d = cnt_q + 1'b1;
        end
        // The timeout is only flagged; the arbiter keeps waiting for the ack
        if (TIMEOUT != 0 && cnt_d == CNT_W'(TIMEOUT)) begin
          err_d = 1'b1;
        end
        if (mem_ack_i) begin
          last_d   = grant_q[PORT_D];
          grant_d  = '0;
          mem_en_d = 1'b0;
          mem_wr_d = 1'b0;
          state_d  = GAP;
        end
      end
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      last_q   <= 1'b1;
      mem_en_q <= 1'b0;
      mem_wr_q <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      last_q   <= last_d;
      mem_en_q <= mem_en_d;
      mem_wr_q <= mem_wr_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
    end
  end

  assign p0_ack_o     = mem_ack_i & grant_q[PORT_I] & (state_q == BUSY);
  assign p1_ack_o     = mem_ack_i & grant_q[PORT_D] & (state_q == BUSY);
  assign p0_data_o    = grant_q[PORT_I] ? mem_data_i : '0;
  assign p1_data_o    = grant_q[PORT_D] ? mem_data_i : '0;
  assign mem_enable_o = mem_en_q;
  assign mem_write_o  = mem_wr_q;
  assign mem_addr_o   = addr_q;
  assign mem_data_o   = data_q;
  assign grant_o      = grant_q;
  assign busy_o       = (state_q != IDLE);
  assign err_o        = err_q;

endmodule
